// File: rtl/cruise_setpoint_controller.sv
// rtl/cruise_setpoint_controller.sv - button sequencing FSM driving the cruise setpoint up/down counter
module cruise_setpoint_controller #(
    parameter int WIDTH    = 3,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cruise_on,
    input  logic             set_btn,
    input  logic             resume_btn,
    input  logic             accel_btn,
    input  logic             decel_btn,
    input  logic             max_btn,
    input  logic             brake,
    input  logic [WIDTH-1:0] speed_in,
    output logic             cnt_enable,
    output logic             cnt_mode,
    output logic             cnt_clear,
    output logic             cnt_preset,
    output logic [1:0]       state,
    output logic             cruise_active
);

    localparam logic [1:0] S_OFF     = 2'b00;
    localparam logic [1:0] S_STANDBY = 2'b01;
    localparam logic [1:0] S_ACTIVE  = 2'b10;
    localparam logic [1:0] S_SUSPEND = 2'b11;

    localparam int             PW        = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]  RELOAD    = PW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_SPEED = '1;

    logic [1:0]    nxt_state;
    logic          set_q, resume_q, accel_q, decel_q, max_q;
    logic [PW-1:0] pcnt, nxt_pcnt;
    logic          nxt_en, nxt_mode, nxt_clr, nxt_pre;
    logic          set_edge, resume_edge, max_edge, press, eligible, step_slot, holdoff;

    assign set_edge    = set_btn & ~set_q;
    assign resume_edge = resume_btn & ~resume_q;
    assign max_edge    = max_btn & ~max_q;
    assign press       = (accel_btn & ~decel_btn & ~accel_q) | (decel_btn & ~accel_btn & ~decel_q);
    assign eligible    = (state == S_ACTIVE) & cruise_on & ~brake & (accel_btn ^ decel_btn);
    // A slot fires on the press edge and whenever the prescaler runs out; saturated slots still count.
    assign step_slot   = eligible & (press | (pcnt == '0));
    assign nxt_pcnt    = (!eligible || step_slot) ? RELOAD : pcnt - 1'b1;
    assign holdoff     = cnt_enable | cnt_clear | cnt_preset;
    assign cruise_active = (state == S_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        if (!cruise_on) begin
            nxt_state = S_OFF;
        end else begin
            case (state)
                S_OFF:     nxt_state = S_STANDBY;
                S_STANDBY: if (!brake && set_edge) nxt_state = S_ACTIVE;
                S_ACTIVE:  if (brake) nxt_state = S_SUSPEND;
                S_SUSPEND: if (!brake && (set_edge || resume_edge)) nxt_state = S_ACTIVE;
                default:   nxt_state = S_OFF;
            endcase
        end
    end

    always_comb begin
        nxt_en   = 1'b0;
        nxt_mode = 1'b0;
        nxt_clr  = 1'b0;
        nxt_pre  = 1'b0;
        if (!cruise_on) begin
            nxt_clr = (state != S_OFF);
        end else if (state == S_OFF) begin
            nxt_clr = 1'b1;
        end else if (state == S_ACTIVE && !brake) begin
            if (max_edge) begin
                nxt_pre = 1'b1;
            end else if (step_slot && (decel_btn ? (speed_in != '0) : (speed_in != MAX_SPEED))) begin
                nxt_en   = 1'b1;
                nxt_mode = decel_btn;
            end
        end
        // One quiet cycle after every command so the next decision sees the updated counter.
        if (holdoff) begin
            nxt_en   = 1'b0;
            nxt_mode = 1'b0;
            nxt_clr  = 1'b0;
            nxt_pre  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_enable <= 1'b0;
            cnt_mode   <= 1'b0;
            cnt_clear  <= 1'b0;
            cnt_preset <= 1'b0;
            pcnt       <= '0;
            set_q      <= 1'b0;
            resume_q   <= 1'b0;
            accel_q    <= 1'b0;
            decel_q    <= 1'b0;
            max_q      <= 1'b0;
        end else begin
            cnt_enable <= nxt_en;
            cnt_mode   <= nxt_mode;
            cnt_clear  <= nxt_clr;
            cnt_preset <= nxt_pre;
            pcnt       <= nxt_pcnt;
            set_q      <= set_btn;
            resume_q   <= resume_btn;
            accel_q    <= accel_btn;
            decel_q    <= decel_btn;
            max_q      <= max_btn;
        end
    end

endmodule

// File: tb/tb_cruise_setpoint_controller.sv
// tb/tb_cruise_setpoint_controller.sv - directed and random checks against a cycle-level button model
module tb_cruise_setpoint_controller;

    localparam int WIDTH    = 3;
    localparam int STEP_DIV = 4;
    localparam int MAXV     = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cruise_on = 1'b0, set_btn = 1'b0, resume_btn = 1'b0;
    logic accel_btn = 1'b0, decel_btn = 1'b0, max_btn = 1'b0, brake = 1'b0;
    logic [WIDTH-1:0] cnt = '0;
    logic cnt_enable, cnt_mode, cnt_clear, cnt_preset, cruise_active;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    int m_state = 0, sp = 0, since = 0;
    bit m_en = 0, m_mode = 0, m_clr = 0, m_pre = 0;
    bit p_set = 0, p_res = 0, p_acc = 0, p_dec = 0, p_max = 0;

    cruise_setpoint_controller #(.WIDTH(WIDTH), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cruise_on(cruise_on), .set_btn(set_btn),
        .resume_btn(resume_btn), .accel_btn(accel_btn), .decel_btn(decel_btn),
        .max_btn(max_btn), .brake(brake), .speed_in(cnt),
        .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_clear(cnt_clear),
        .cnt_preset(cnt_preset), .state(state), .cruise_active(cruise_active)
    );

    always #5 clk = ~clk;

    // The three-bit counter the controller drives.
    always @(posedge clk) begin
        if (cnt_clear) cnt <= '0;
        else if (cnt_preset) cnt <= '1;
        else if (cnt_enable) cnt <= cnt_mode ? cnt - 1'b1 : cnt + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; since = 0;
        m_en = 0; m_mode = 0; m_clr = 0; m_pre = 0;
        p_set = 0; p_res = 0; p_acc = 0; p_dec = 0; p_max = 0;
    endtask

    task automatic model_step();
        bit e_set, e_res, e_max, press, elig, slot, any_prev, dn;
        bit w_en, w_clr, w_pre;
        int ns;
        any_prev = m_en | m_clr | m_pre;
        if (m_clr) sp = 0;
        else if (m_pre) sp = MAXV;
        else if (m_en) sp = m_mode ? sp - 1 : sp + 1;
        e_set = set_btn & !p_set;
        e_res = resume_btn & !p_res;
        e_max = max_btn & !p_max;
        press = (accel_btn && !decel_btn && !p_acc) || (decel_btn && !accel_btn && !p_dec);
        elig  = (m_state == 2) && cruise_on && !brake && (accel_btn != decel_btn);
        slot  = 0;
        if (!elig) since = 0;
        else if (press) begin since = 0; slot = 1; end
        else begin since++; slot = (since % STEP_DIV) == 0; end
        w_en = 0; w_clr = 0; w_pre = 0; dn = decel_btn; ns = m_state;
        if (!cruise_on) begin
            w_clr = (m_state != 0);
            ns = 0;
        end else begin
            case (m_state)
                0: begin ns = 1; w_clr = 1; end
                1: if (!brake && e_set) ns = 2;
                2: if (brake) ns = 3;
                   else if (e_max) w_pre = 1;
                   else if (slot) w_en = dn ? (sp != 0) : (sp != MAXV);
                default: if (!brake && (e_set || e_res)) ns = 2;
            endcase
        end
        if (any_prev) begin w_en = 0; w_clr = 0; w_pre = 0; end
        m_en = w_en; m_mode = w_en & dn; m_clr = w_clr; m_pre = w_pre; m_state = ns;
        p_set = set_btn; p_res = resume_btn; p_acc = accel_btn; p_dec = decel_btn; p_max = max_btn;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("outputs", {state, cnt_enable, cnt_mode & cnt_enable, cnt_clear, cnt_preset, cruise_active},
            {m_state[1:0], m_en, m_mode, m_clr, m_pre, m_state == 2});
        chk("speed", cnt, sp);
    endtask

    int n_en, n_clr, n_pre;
    logic [9:0] en_mask;

    initial begin
        // 1: reset, then power up
        for (int i = 0; i < 3; i++) tick();
        chk("reset_state", state, 0);
        rst_n = 1'b1;
        cruise_on = 1'b1;
        n_clr = 0;
        for (int i = 0; i < 4; i++) begin tick(); n_clr += cnt_clear; end
        chk("powerup_clears", n_clr, 1);
        chk("standby", state, 1);

        // 2: engage, hold accel 10 cycles
        set_btn = 1'b1; tick();
        set_btn = 1'b0; tick();
        accel_btn = 1'b1;
        en_mask = '0;
        for (int i = 0; i < 10; i++) begin tick(); en_mask[i] = cnt_enable & ~cnt_mode; end
        accel_btn = 1'b0; tick();
        chk("accel_pattern", en_mask, 10'b01_0001_0001);
        chk("sp_after_accel", cnt, 3);
        chk("active_flag", cruise_active, 1);

        // 3: saturate at both ends
        accel_btn = 1'b1; n_en = 0;
        for (int i = 0; i < 24; i++) begin tick(); n_en += cnt_enable; end
        accel_btn = 1'b0; tick();
        chk("up_steps", n_en, 4);
        chk("sp_max", cnt, MAXV);
        decel_btn = 1'b1; n_en = 0;
        for (int i = 0; i < 40; i++) begin tick(); n_en += cnt_enable; end
        decel_btn = 1'b0; tick();
        chk("down_steps", n_en, MAXV);
        chk("sp_zero", cnt, 0);

        // 4: brake mid-hold at setpoint 2, then resume
        accel_btn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        brake = 1'b1; tick();
        chk("brake_state", state, 3);
        chk("brake_no_enable", cnt_enable, 0);
        brake = 1'b0; accel_btn = 1'b0; tick();
        resume_btn = 1'b1; tick();
        resume_btn = 1'b0; tick();
        chk("resumed", state, 2);
        chk("sp_kept", cnt, 2);

        // 5: both direction buttons, then max
        accel_btn = 1'b1; decel_btn = 1'b1; n_en = 0;
        for (int i = 0; i < 12; i++) begin tick(); n_en += cnt_enable | cnt_preset | cnt_clear; end
        chk("both_held", n_en, 0);
        accel_btn = 1'b0; decel_btn = 1'b0; tick(); tick();
        max_btn = 1'b1; n_pre = 0;
        tick(); n_pre += cnt_preset;
        max_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); n_pre += cnt_preset; end
        chk("max_presets", n_pre, 1);
        chk("sp_preset", cnt, MAXV);

        // 6: master switch drops mid-hold
        decel_btn = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        cruise_on = 1'b0; tick();
        chk("off_state", state, 0);
        chk("off_clear", cnt_clear, 1);
        decel_btn = 1'b0; tick();
        chk("off_single_clear", cnt_clear, 0);
        chk("sp_cleared", cnt, 0);

        // async reset while a step is pending
        cruise_on = 1'b1; tick(); tick();
        set_btn = 1'b1; tick();
        set_btn = 1'b0; tick();
        accel_btn = 1'b1; tick();
        chk("pending_step", cnt_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {state, cnt_enable, cnt_mode, cnt_clear, cnt_preset, cruise_active}, 0);
        model_reset();
        @(negedge clk);
        accel_btn = 1'b0; cruise_on = 1'b0;
        tick();
        rst_n = 1'b1;

        // random phase
        for (int i = 0; i < 800; i++) begin
            cruise_on  = ($urandom % 60) != 0;
            if ($urandom % 15 == 0) brake = ~brake;
            if ($urandom % 7 == 0) accel_btn = ~accel_btn;
            if ($urandom % 9 == 0) decel_btn = ~decel_btn;
            set_btn    = ($urandom % 8) == 0;
            resume_btn = ($urandom % 8) == 0;
            max_btn    = ($urandom % 25) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
